pmem_accum: RTL and testbench
=============================

Name: pmem_accum

Overview:
- Parametrised partial-sum memory with a built-in read-modify-write accumulator, next generation of the fake psum store.
- The PE array streams signed partial sums in; each write either overwrites a word or adds to it (2-stage pipeline with bypass), with optional saturation.
- An independent read port drains results; a clear sequencer zeroes the whole array between layers.

Parameters:
- IN_WIDTH, 16: width of incoming signed partial sum.
- DATA_WIDTH, 24: width of stored signed accumulator word (must be >= IN_WIDTH).
- ADDR_WIDTH, 8: address bus width.
- DEPTH, 256: implemented words (<= 2**ADDR_WIDTH).
- SATURATE, 1: 1 = clamp on overflow; 0 = two's-complement wrap.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_wr_en  in  1  write request.
- i_acc_en  in  1  qualifies i_wr_en: 1 = accumulate into word, 0 = overwrite.
- i_wr_addr  in  ADDR_WIDTH  write address.
- i_wr_data  in  IN_WIDTH  signed partial sum.
- i_rd_en  in  1  read request.
- i_rd_addr  in  ADDR_WIDTH  read address.
- o_rd_data  out  DATA_WIDTH  read data.
- o_rd_valid  out  1  o_rd_data valid this cycle.
- i_clr  in  1  single-cycle pulse: zero the whole array.
- o_busy  out  1  clear or drain in progress; requests ignored.
- o_sat  out  1  sticky overflow flag.

Behaviour:
- Reset: FSM=IDLE; pipeline valids=0; o_rd_valid=0, o_rd_data=0, o_busy=0, o_sat=0. Array contents are not reset.
- Write pipeline:
  - S1 (edge N): request captured; RAM read of old word issued.
  - S2 (cycle N+1): old word available; result = acc ? old + sext(i_wr_data) : sext(i_wr_data); committed at edge N+2.
  - One request per cycle, no stall.
- Bypass: if the S1 address equals the S2 address being committed, S1 uses the S2 result, not the stale RAM word. Back-to-back accumulates to one address must equal the sequential sum.
- Overflow (accumulate only): if old and sext(data) share a sign and the sum sign differs:
  - SATURATE=1: clamp to +2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1).
  - SATURATE=0: wrap.
  - Either way o_sat sets and stays high until i_rst or a clear starts.
- Read:
  - 1-cycle latency: o_rd_valid high exactly the cycle after accepted i_rd_en.
  - o_rd_data holds its last value when invalid.
  - Returns the word committed before the read edge. No forwarding from S1/S2, so a same-cycle commit is not visible.
- Out-of-range (addr >= DEPTH): writes dropped (no o_sat effect); reads return 0 with o_rd_valid=1.
- FSM (IDLE, DRAIN, CLEAR):
  - IDLE + i_clr: go to DRAIN if S1 or S2 is valid, else CLEAR. The i_clr cycle's own write/read requests are ignored.
  - DRAIN: in-flight writes commit; go to CLEAR once the pipeline is empty.
  - CLEAR: writes 0 to address 0..DEPTH-1, one per cycle; o_sat cleared on entry; after address DEPTH-1 return to IDLE.
  - o_busy=1 in DRAIN and CLEAR. i_wr_en, i_rd_en and i_clr are ignored while busy; o_rd_valid stays 0 (except the read accepted before busy).
- i_rst mid-clear or mid-pipeline: immediate return to IDLE, in-flight writes discarded, partially cleared array left as is.

Decomposition:
- Shared package: FSM state enum (IDLE/DRAIN/CLEAR), default widths, saturation max/min constant functions of DATA_WIDTH.
- Sub-module pmem_dp_ram: DEPTH x DATA_WIDTH, one write port, two registered read ports (accumulate port, external port), no reset, read-old-data on collision.
- Pipeline, bypass, saturation and FSM live in pmem_accum.

Test Plan:
- Overwrite 0x1234 @5, then read @5 -> o_rd_valid 1 cycle after i_rd_en, o_rd_data=0x001234; negative 0x8000 -> 0xFF8000 (sign-extended).
- Accumulate +3, +4, -2 to @7 on consecutive cycles after overwrite 10 -> read @7 returns 15 (bypass exercised).
- Overwrite @9 = 0x7FFFF0, then accumulate +0x7FFF (SATURATE=1) -> 0x7FFFFF, o_sat=1. Same with SATURATE=0 -> 0x807FEF (wrapped), o_sat=1.
- Accumulate in flight when i_clr pulses -> DRAIN lets it commit, then o_busy high for exactly DEPTH cycles. Reads of 0, 128, 255 afterwards return 0; o_sat=0.
- Write/read to addr >= DEPTH (DEPTH=200, addr 210) -> no array change; read returns 0 with o_rd_valid=1.
- Assert i_rst at clear address 50 -> next cycle o_busy=0, FSM IDLE; a write then read @100 behaves normally.

Source files
------------

// File: rtl/pmem_accum_pkg.sv
// Shared types and constants for the partial-sum accumulator memory.
// Holds the control FSM states, default widths and the saturation limits.
package pmem_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_CLEAR
    } state_t;

    localparam int DEF_IN_WIDTH   = 16;
    localparam int DEF_DATA_WIDTH = 24;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DEPTH      = 256;

    // Largest positive / most negative two's-complement value of a given width,
    // returned zero-extended in 64 bits for the caller to truncate.
    function automatic logic [63:0] sat_max_f(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min_f(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/pmem_accum_dp_ram.sv
// Storage array: one write port, two registered read ports, no reset.
// A read that collides with a write to the same word returns the old word.
module pmem_dp_ram #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_a_en,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    output logic [DATA_WIDTH-1:0] o_a_data,
    input  logic                  i_b_en,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    output logic [DATA_WIDTH-1:0] o_b_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] a_data_q, a_data_d;
    logic [DATA_WIDTH-1:0] b_data_q, b_data_d;

    always_comb begin
        a_data_d = a_data_q;
        b_data_d = b_data_q;
        if (i_a_en) a_data_d = mem_q[i_a_addr];
        if (i_b_en) b_data_d = mem_q[i_b_addr];
    end

    always_ff @(posedge i_clk) begin
        if (i_we) mem_q[i_waddr] <= i_wdata;
        a_data_q <= a_data_d;
        b_data_q <= b_data_d;
    end

    assign o_a_data = a_data_q;
    assign o_b_data = b_data_q;

endmodule

// File: rtl/pmem_accum.sv
// Partial-sum memory with a two-stage read-modify-write accumulator,
// an independent read port and a whole-array clear sequencer.
module pmem_accum
    import pmem_accum_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int SATURATE   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic                  i_acc_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [IN_WIDTH-1:0]   i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    input  logic                  i_clr,
    output logic                  o_busy,
    output logic                  o_sat
);

    localparam logic [DATA_WIDTH-1:0] SAT_MAX    = DATA_WIDTH'(sat_max_f(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] SAT_MIN    = DATA_WIDTH'(sat_min_f(DATA_WIDTH));
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam int                    MSB        = DATA_WIDTH - 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_acc_q, s1_acc_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic [IN_WIDTH-1:0]   s1_data_q, s1_data_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;
    logic [DATA_WIDTH-1:0] s2_result_q, s2_result_d;
    logic                  fwd_valid_q, fwd_valid_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
    logic                  sat_q, sat_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_zero_q, rd_zero_d;

    logic                  accept;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  rd_in_range;
    logic                  clear_entry;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] addend;
    logic [DATA_WIDTH-1:0] sum;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] result;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_a_data;
    logic [DATA_WIDTH-1:0] ram_b_data;

    pmem_dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .i_clk    (i_clk),
        .i_we     (ram_we),
        .i_waddr  (ram_waddr),
        .i_wdata  (ram_wdata),
        .i_a_en   (wr_accept),
        .i_a_addr (i_wr_addr),
        .o_a_data (ram_a_data),
        .i_b_en   (rd_accept && rd_in_range),
        .i_b_addr (i_rd_addr),
        .o_b_data (ram_b_data)
    );

    always_comb begin
        accept      = (state_q == ST_IDLE) && !i_clr;
        wr_accept   = accept && i_wr_en && ({1'b0, i_wr_addr} < DEPTH_EXT);
        rd_in_range = {1'b0, i_rd_addr} < DEPTH_EXT;
        rd_accept   = accept && i_rd_en;
    end

    // The RAM word seen by S1 can be stale twice over: S2 is about to write the
    // same address, or a write landed on the very edge S1 issued its read.
    always_comb begin
        old_word = ram_a_data;
        if (s2_valid_q && (s2_addr_q == s1_addr_q)) begin
            old_word = s2_result_q;
        end else if (fwd_valid_q) begin
            old_word = fwd_data_q;
        end
        addend   = DATA_WIDTH'($signed(s1_data_q));
        sum      = old_word + addend;
        overflow = s1_acc_q && (old_word[MSB] == addend[MSB]) && (sum[MSB] != old_word[MSB]);
        if (!s1_acc_q) begin
            result = addend;
        end else if (overflow && (SATURATE != 0)) begin
            result = old_word[MSB] ? SAT_MIN : SAT_MAX;
        end else begin
            result = sum;
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = s2_addr_q;
        ram_wdata = s2_result_q;
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr_q;
            ram_wdata = '0;
        end else if (s2_valid_q) begin
            ram_we = 1'b1;
        end
        if (i_rst) ram_we = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (i_clr) begin
                    if (s1_valid_q || s2_valid_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d    = ST_CLEAR;
                        clr_addr_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_addr_q == DEPTH_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        clear_entry = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);
        s1_valid_d  = wr_accept;
        s1_acc_d    = i_acc_en;
        s1_addr_d   = i_wr_addr;
        s1_data_d   = i_wr_data;
        s2_valid_d  = s1_valid_q;
        s2_addr_d   = s1_addr_q;
        s2_result_d = result;
        fwd_valid_d = ram_we && (ram_waddr == i_wr_addr);
        fwd_data_d  = ram_wdata;
        sat_d       = sat_q;
        if (s1_valid_q && overflow) sat_d = 1'b1;
        if (clear_entry) sat_d = 1'b0;
        rd_valid_d  = rd_accept;
        rd_zero_d   = rd_accept ? !rd_in_range : rd_zero_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            clr_addr_q  <= '0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            fwd_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_zero_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            fwd_valid_q <= fwd_valid_d;
            sat_q       <= sat_d;
            rd_valid_q  <= rd_valid_d;
            rd_zero_q   <= rd_zero_d;
        end
    end

    always_ff @(posedge i_clk) begin
        s1_acc_q    <= s1_acc_d;
        s1_addr_q   <= s1_addr_d;
        s1_data_q   <= s1_data_d;
        s2_addr_q   <= s2_addr_d;
        s2_result_q <= s2_result_d;
        fwd_data_q  <= fwd_data_d;
    end

    assign o_rd_data  = rd_zero_q ? '0 : ram_b_data;
    assign o_rd_valid = rd_valid_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_sat      = sat_q;

endmodule

// File: tb/tb_pmem_accum.sv
// Directed bench for pmem_accum: a saturating 256-word instance and a
// wrapping 200-word instance driven from the same stimulus.
module tb_pmem_accum;

    typedef struct {
        logic        wr_en;
        logic        acc_en;
        logic [7:0]  wr_addr;
        logic [15:0] wr_data;
        logic        rd_en;
        logic [7:0]  rd_addr;
        logic        exp_valid;
        logic [23:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, acc_en, rd_en, clr;
    logic [7:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic [23:0] m_data, w_data;
    logic        m_valid, w_valid, m_busy, w_busy, m_sat, w_sat;

    int tests_run    = 0;
    int tests_failed = 0;

    vec_t vecs [22];

    always #5 clk = ~clk;

    pmem_accum dut (
        .i_clk (clk), .i_rst (rst), .i_wr_en (wr_en), .i_acc_en (acc_en),
        .i_wr_addr (wr_addr), .i_wr_data (wr_data), .i_rd_en (rd_en),
        .i_rd_addr (rd_addr), .o_rd_data (m_data), .o_rd_valid (m_valid),
        .i_clr (clr), .o_busy (m_busy), .o_sat (m_sat)
    );

    pmem_accum #(.DEPTH(200), .SATURATE(0)) dut_w (
        .i_clk (clk), .i_rst (rst), .i_wr_en (wr_en), .i_acc_en (acc_en),
        .i_wr_addr (wr_addr), .i_wr_data (wr_data), .i_rd_en (rd_en),
        .i_rd_addr (rd_addr), .o_rd_data (w_data), .o_rd_valid (w_valid),
        .i_clr (clr), .o_busy (w_busy), .o_sat (w_sat)
    );

    // Drive one cycle of inputs on the falling edge, then let the rising edge
    // sample them and settle so outputs can be checked.
    task automatic applyStimulus(input logic we, input logic ae, input logic [7:0] wa,
                                 input logic [15:0] wd, input logic re,
                                 input logic [7:0] ra, input logic c);
        @(negedge clk);
        wr_en = we; acc_en = ae; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic readBoth(input logic [7:0] addr);
        applyStimulus(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, addr, 1'b0);
    endtask

    initial begin
        int cnt_m, cnt_w, guard;
        logic rd_bad;

        rst = 1'b1; wr_en = 0; acc_en = 0; wr_addr = 0; wr_data = 0;
        rd_en = 0; rd_addr = 0; clr = 0;
        repeat (3) idle();
        checkOutput("reset m_valid", m_valid, 0);
        checkOutput("reset m_data", m_data, 0);
        checkOutput("reset m_busy", m_busy, 0);
        checkOutput("reset m_sat", m_sat, 0);
        checkOutput("reset w_valid", w_valid, 0);
        checkOutput("reset w_data", w_data, 0);
        checkOutput("reset w_busy", w_busy, 0);
        checkOutput("reset w_sat", w_sat, 0);
        @(negedge clk);
        rst = 1'b0;

        vecs[0]  = '{1'b1, 1'b0, 8'd5,  16'h1234, 1'b0, 8'd0,  1'b0, 24'h000000};
        vecs[1]  = '{1'b1, 1'b0, 8'd6,  16'h8000, 1'b0, 8'd0,  1'b0, 24'h000000};
        vecs[2]  = '{1'b1, 1'b0, 8'd7,  16'h000A, 1'b0, 8'd0,  1'b0, 24'h000000};
        vecs[3]  = '{1'b1, 1'b1, 8'd7,  16'h0003, 1'b0, 8'd0,  1'b0, 24'h000000};
        vecs[4]  = '{1'b1, 1'b1, 8'd7,  16'h0004, 1'b0, 8'd0,  1'b0, 24'h000000};
        vecs[5]  = '{1'b1, 1'b1, 8'd7,  16'hFFFE, 1'b0, 8'd0,  1'b0, 24'h000000};
        vecs[6]  = '{1'b1, 1'b0, 8'd20, 16'h0011, 1'b1, 8'd5,  1'b1, 24'h001234};
        vecs[7]  = '{1'b0, 1'b0, 8'd0,  16'h0000, 1'b1, 8'd6,  1'b1, 24'hFF8000};
        vecs[8]  = '{1'b1, 1'b0, 8'd20, 16'h0055, 1'b0, 8'd0,  1'b0, 24'hFF8000};
        vecs[9]  = '{1'b0, 1'b0, 8'd0,  16'h0000, 1'b1, 8'd7,  1'b1, 24'h00000F};
        vecs[10] = '{1'b0, 1'b0, 8'd0,  16'h0000, 1'b1, 8'd20, 1'b1, 24'h000011};
        vecs[11] = '{1'b0, 1'b0, 8'd0,  16'h0000, 1'b1, 8'd20, 1'b1, 24'h000055};
        vecs[12] = '{1'b1, 1'b1, 8'd20, 16'h0001, 1'b1, 8'd20, 1'b1, 24'h000055};
        vecs[13] = '{1'b0, 1'b0, 8'd0,  16'h0000, 1'b0, 8'd0,  1'b0, 24'h000055};
        vecs[14] = '{1'b0, 1'b0, 8'd0,  16'h0000, 1'b1, 8'd20, 1'b1, 24'h000055};
        vecs[15] = '{1'b0, 1'b0, 8'd0,  16'h0000, 1'b1, 8'd20, 1'b1, 24'h000056};
        vecs[16] = '{1'b1, 1'b0, 8'd30, 16'h0064, 1'b0, 8'd0,  1'b0, 24'h000056};
        vecs[17] = '{1'b0, 1'b0, 8'd0,  16'h0000, 1'b0, 8'd0,  1'b0, 24'h000056};
        vecs[18] = '{1'b1, 1'b1, 8'd30, 16'h0005, 1'b0, 8'd0,  1'b0, 24'h000056};
        vecs[19] = '{1'b0, 1'b0, 8'd0,  16'h0000, 1'b0, 8'd0,  1'b0, 24'h000056};
        vecs[20] = '{1'b0, 1'b0, 8'd0,  16'h0000, 1'b0, 8'd0,  1'b0, 24'h000056};
        vecs[21] = '{1'b0, 1'b0, 8'd0,  16'h0000, 1'b1, 8'd30, 1'b1, 24'h000069};

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].wr_en, vecs[i].acc_en, vecs[i].wr_addr, vecs[i].wr_data,
                          vecs[i].rd_en, vecs[i].rd_addr, 1'b0);
            checkOutput($sformatf("vec%0d valid", i), m_valid, vecs[i].exp_valid);
            checkOutput($sformatf("vec%0d data", i), m_data, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d sat", i), m_sat, 0);
        end

        // Build 0x7FFFF0 at @9 out of 16-bit steps, then push it past the top.
        applyStimulus(1'b1, 1'b0, 8'd9, 16'h7FFF, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 255; i++) applyStimulus(1'b1, 1'b1, 8'd9, 16'h7FFF, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'd9, 16'h00F0, 1'b0, 8'd0, 1'b0);
        idle(); idle();
        readBoth(8'd9);
        checkOutput("pre-sat m_data", m_data, 24'h7FFFF0);
        checkOutput("pre-sat w_data", w_data, 24'h7FFFF0);
        checkOutput("pre-sat m_sat", m_sat, 0);
        applyStimulus(1'b1, 1'b1, 8'd9, 16'h7FFF, 1'b0, 8'd0, 1'b0);
        idle(); idle();
        readBoth(8'd9);
        checkOutput("sat m_data", m_data, 24'h7FFFFF);
        checkOutput("sat m_sat", m_sat, 1);
        checkOutput("wrap w_data", w_data, 24'h807FEF);
        checkOutput("wrap w_sat", w_sat, 1);

        // Clear arriving while an accumulate is still in the pipeline.
        applyStimulus(1'b1, 1'b1, 8'd9, 16'h0001, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'd0, 16'h0000, 1'b1, 8'd0, 1'b1);
        cnt_m = 0; cnt_w = 0; guard = 0; rd_bad = 1'b0;
        while ((m_busy || w_busy) && guard < 2000) begin
            cnt_m += int'(m_busy);
            cnt_w += int'(w_busy);
            if ((m_busy && m_valid) || (w_busy && w_valid)) rd_bad = 1'b1;
            applyStimulus(1'b0, 1'b0, 8'd0, 16'h0000, 1'b1, 8'd0, 1'b0);
            guard++;
        end
        checkOutput("drain clear timeout", guard < 2000, 1);
        checkOutput("drain clear m busy cycles", cnt_m, 258);
        checkOutput("drain clear w busy cycles", cnt_w, 202);
        checkOutput("reads ignored while busy", rd_bad, 0);
        checkOutput("last busy read ignored", m_valid, 0);
        checkOutput("clear m_sat", m_sat, 0);
        checkOutput("clear w_sat", w_sat, 0);
        readBoth(8'd0);
        checkOutput("clr @0 valid", m_valid, 1);
        checkOutput("clr @0 data", m_data, 0);
        readBoth(8'd128);
        checkOutput("clr @128 data", m_data, 0);
        readBoth(8'd255);
        checkOutput("clr @255 data", m_data, 0);
        readBoth(8'd9);
        checkOutput("clr @9 data", m_data, 0);

        // Address 210 is in range for the 256-word instance only.
        applyStimulus(1'b1, 1'b0, 8'd210, 16'h0123, 1'b0, 8'd0, 1'b0);
        idle(); idle();
        readBoth(8'd210);
        checkOutput("oor m_data", m_data, 24'h000123);
        checkOutput("oor w_valid", w_valid, 1);
        checkOutput("oor w_data", w_data, 0);
        checkOutput("oor w_sat", w_sat, 0);
        readBoth(8'd10);
        checkOutput("oor no alias w_data", w_data, 0);

        // Clear with an empty pipeline goes straight to CLEAR.
        applyStimulus(1'b0, 1'b0, 8'd0, 16'h0000, 1'b0, 8'd0, 1'b1);
        cnt_m = 0; cnt_w = 0; guard = 0;
        while ((m_busy || w_busy) && guard < 2000) begin
            cnt_m += int'(m_busy);
            cnt_w += int'(w_busy);
            idle();
            guard++;
        end
        checkOutput("empty clear timeout", guard < 2000, 1);
        checkOutput("empty clear m busy cycles", cnt_m, 256);
        checkOutput("empty clear w busy cycles", cnt_w, 200);

        // Reset in the middle of a clear, with one word below and one above.
        applyStimulus(1'b1, 1'b0, 8'd20, 16'h0077, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd150, 16'h0BEE, 1'b0, 8'd0, 1'b0);
        idle(); idle();
        applyStimulus(1'b0, 1'b0, 8'd0, 16'h0000, 1'b0, 8'd0, 1'b1);
        cnt_m = 1;
        while (cnt_m < 51) begin
            idle();
            cnt_m++;
        end
        checkOutput("busy before reset", m_busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid-clear reset m_busy", m_busy, 0);
        checkOutput("mid-clear reset w_busy", w_busy, 0);
        checkOutput("mid-clear reset m_valid", m_valid, 0);
        checkOutput("mid-clear reset m_data", m_data, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'd100, 16'h0042, 1'b0, 8'd0, 1'b0);
        idle(); idle();
        readBoth(8'd100);
        checkOutput("post-reset @100 m", m_data, 24'h000042);
        checkOutput("post-reset @100 w", w_data, 24'h000042);
        checkOutput("post-reset @100 valid", m_valid, 1);
        readBoth(8'd20);
        checkOutput("partial clear @20", m_data, 0);
        readBoth(8'd150);
        checkOutput("partial clear @150", m_data, 24'h000BEE);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
